// File: rtl/ram_pkg.sv
// Shared BIST types: FSM state encoding and the address-derived test pattern.
// Used by the RTL and by the bench reference model so both agree on data.
package ram_pkg;

    localparam int PAT_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_TURN,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } bist_state_e;

    // Callers zero-extend into PAT_W and truncate the result to the word width.
    function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] a,
                                             input logic [PAT_W-1:0] seed);
        return a ^ seed;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Control/status bundle between a test requester (master) and the BIST engine (slave).
// Start is a level sampled in IDLE; results hold until the next accepted start.
interface ram_bist_if #(
    parameter int wordSize    = 8,
    parameter int addressSize = 32,
    parameter int errWidth    = 16
);
    logic                   start;
    logic [addressSize-1:0] startAddr;
    logic [addressSize-1:0] endAddr;
    logic [wordSize-1:0]    seed;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [errWidth-1:0]    errCount;
    logic [addressSize-1:0] firstErrAddr;

    modport master (
        output start, startAddr, endAddr, seed,
        input  busy, done, pass, errCount, firstErrAddr
    );

    modport slave (
        input  start, startAddr, endAddr, seed,
        output busy, done, pass, errCount, firstErrAddr
    );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Window registers and wrapping address counter; inc on the last word rewinds to the window start.
// cur is registered (updates one edge after load/inc); no backpressure, caller sequences load/inc.
module ram_bist_addr_gen #(
    parameter int addressSize = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   inc,
    input  logic [addressSize-1:0] start_addr,
    input  logic [addressSize-1:0] end_addr,
    output logic [addressSize-1:0] cur,
    output logic [addressSize-1:0] cur_nxt,
    output logic                   last
);
    logic [addressSize-1:0] start_q, start_d;
    logic [addressSize-1:0] end_q, end_d;
    logic [addressSize-1:0] cur_q, cur_d;

    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        cur_d   = cur_q;
        if (load) begin
            start_d = start_addr;
            end_d   = end_addr;
            cur_d   = start_addr;
        end else if (inc) begin
            cur_d = (cur_q == end_q) ? start_q : cur_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            end_q   <= '0;
            cur_q   <= '0;
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
            cur_q   <= cur_d;
        end
    end

    assign cur     = cur_q;
    assign cur_nxt = cur_d;
    assign last    = (cur_q == end_q);
endmodule

// File: rtl/ram_bist.sv
// RAM BIST initiator: writes pat(addr) over a window, reads back with two cycles per word, reports pass/fail.
// 3N+2 cycles from start to done for N words; start is ignored while busy, no other flow control.
module ram_bist
    import ram_pkg::*;
#(
    parameter int wordSize    = 8,
    parameter int addressSize = 32,
    parameter int errWidth    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ram_bist_if.slave              ctl,
    output logic                   we,
    output logic                   re,
    output logic [addressSize-1:0] addr,
    inout  wire  [wordSize-1:0]    data
);
    localparam logic [errWidth-1:0] ERR_MAX = '1;

    bist_state_e            state_q, state_d;
    logic                   we_q, we_d, re_q, re_d;
    logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [errWidth-1:0]    err_q, err_d;
    logic [addressSize-1:0] ferr_addr_q, ferr_addr_d;
    logic                   ferr_seen_q, ferr_seen_d;
    logic [wordSize-1:0]    seed_q, seed_d, dat_q, dat_d;
    logic [wordSize-1:0]    exp_dat;
    logic                   ag_load, ag_inc, last;
    logic [addressSize-1:0] cur, cur_nxt;

    ram_bist_addr_gen #(.addressSize(addressSize)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (ag_load),
        .inc        (ag_inc),
        .start_addr (ctl.startAddr),
        .end_addr   (ctl.endAddr),
        .cur        (cur),
        .cur_nxt    (cur_nxt),
        .last       (last)
    );

    assign exp_dat = wordSize'(pat(PAT_W'(cur), PAT_W'(seed_q)));

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
        ferr_addr_d = ferr_addr_q;
        ferr_seen_d = ferr_seen_q;
        seed_d      = seed_q;
        dat_d       = dat_q;
        ag_load     = 1'b0;
        ag_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctl.start) begin
                    ag_load     = 1'b1;
                    seed_d      = ctl.seed;
                    err_d       = '0;
                    ferr_addr_d = '0;
                    ferr_seen_d = 1'b0;
                    busy_d      = 1'b1;
                    we_d        = 1'b1;
                    dat_d       = wordSize'(pat(PAT_W'(ctl.startAddr), PAT_W'(ctl.seed)));
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ag_inc = 1'b1;
                dat_d  = wordSize'(pat(PAT_W'(cur_nxt), PAT_W'(seed_q)));
                if (last) begin
                    state_d = ST_TURN;
                end else begin
                    we_d = 1'b1;
                end
            end
            ST_TURN: begin
                re_d    = 1'b1;
                state_d = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                re_d    = 1'b1;
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // The RAM drives the word addressed in RD_ADDR during this cycle.
                if (data != exp_dat) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ferr_seen_q) begin
                        ferr_addr_d = cur;
                        ferr_seen_d = 1'b1;
                    end
                end
                if (last) begin
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    ag_inc  = 1'b1;
                    re_d    = 1'b1;
                    state_d = ST_RD_ADDR;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_seen_q <= 1'b0;
            seed_q      <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_seen_q <= ferr_seen_d;
            seed_q      <= seed_d;
            dat_q       <= dat_d;
        end
    end

    assign we   = we_q;
    assign re   = re_q;
    assign addr = cur;
    assign data = we_q ? dat_q : {wordSize{1'bz}};

    assign ctl.busy         = busy_q;
    assign ctl.done         = done_q;
    assign ctl.pass         = pass_q;
    assign ctl.errCount     = err_q;
    assign ctl.firstErrAddr = ferr_addr_q;
endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: a behavioural RAM per DUT, one with an addr-2 fault option,
// one that corrupts every read (drives the errWidth=2 saturation instance).
module tb_ram_bist;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] startAddr = '0;
    logic [31:0] endAddr = '0;
    logic [7:0]  seed = '0;
    logic        fault2 = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wq[$];
    logic [31:0] aq[$];

    always #5 clk = ~clk;

    ram_bist_if                   ctl1 ();
    ram_bist_if #(.errWidth(2))   ctl2 ();

    assign ctl1.start = start;  assign ctl1.startAddr = startAddr;
    assign ctl1.endAddr = endAddr;  assign ctl1.seed = seed;
    assign ctl2.start = start;  assign ctl2.startAddr = startAddr;
    assign ctl2.endAddr = endAddr;  assign ctl2.seed = seed;

    wire        we1, re1, we2, re2;
    wire [31:0] addr1, addr2;
    wire [7:0]  data1, data2;

    ram_bist u_dut (
        .clk(clk), .rst(rst), .ctl(ctl1),
        .we(we1), .re(re1), .addr(addr1), .data(data1)
    );

    ram_bist #(.errWidth(2)) u_sat (
        .clk(clk), .rst(rst), .ctl(ctl2),
        .we(we2), .re(re2), .addr(addr2), .data(data2)
    );

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic       oe1, oe2;
    logic [7:0] rv1, rv2;

    always @(posedge clk) begin
        oe1 <= rst ? 1'b0 : re1;
        oe2 <= rst ? 1'b0 : re2;
        if (we1) mem1[addr1[7:0]] <= data1;
        if (we2) mem2[addr2[7:0]] <= data2;
        rv1 <= (fault2 && addr1 == 32'd2) ? 8'hFF : mem1[addr1[7:0]];
        rv2 <= ~mem2[addr2[7:0]];
    end

    assign data1 = oe1 ? rv1 : 8'hzz;
    assign data2 = oe2 ? rv2 : 8'hzz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one start, logs every write on the bus, and checks timing of busy/done.
    task automatic run(input string tag, input logic [31:0] sa, input logic [31:0] ea,
                       input logic [7:0] sd, input int exp_done, input bit poke);
        int done_cyc = 0;
        int busy_bad = 0;
        int both_hi  = 0;
        wq.delete();
        aq.delete();
        @(negedge clk);
        startAddr = sa; endAddr = ea; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= exp_done + 8; c++) begin
            if (we1) begin
                wq.push_back(data1);
                aq.push_back(addr1);
            end
            if (we1 && re1) both_hi++;
            if (busy1_now() != 1'b1) busy_bad++;
            if (poke && c == 2) begin
                start = 1'b1; startAddr = 32'h40; endAddr = 32'h50; seed = 8'h11;
            end else begin
                start = 1'b0;
            end
            if (ctl1.done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
        chk({tag, "_we_re_both"}, 64'(both_hi), 64'd0);
        @(negedge clk);
        chk({tag, "_busy_after"}, 64'(ctl1.busy), 64'd0);
        chk({tag, "_done_pulse"}, 64'(ctl1.done), 64'd0);
    endtask

    function automatic logic busy1_now();
        return ctl1.busy;
    endfunction

    initial begin
        int done_seen;
        repeat (3) @(negedge clk);
        chk("rst_we", 64'(we1), 64'd0);
        chk("rst_re", 64'(re1), 64'd0);
        chk("rst_addr", 64'(addr1), 64'd0);
        chk("rst_busy", 64'(ctl1.busy), 64'd0);
        chk("rst_done", 64'(ctl1.done), 64'd0);
        chk("rst_pass", 64'(ctl1.pass), 64'd0);
        chk("rst_err", 64'(ctl1.errCount), 64'd0);
        chk("rst_ferr", 64'(ctl1.firstErrAddr), 64'd0);
        rst = 1'b0;

        // Clean run: 4 words, seed 0.
        run("clean", 32'd0, 32'd3, 8'h00, 14, 1'b0);
        chk("clean_nwr", 64'(wq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("clean_wdat%0d", i), 64'(wq[i]), 64'(i));
            chk($sformatf("clean_waddr%0d", i), 64'(aq[i]), 64'(i));
        end
        chk("clean_pass", 64'(ctl1.pass), 64'd1);
        chk("clean_err", 64'(ctl1.errCount), 64'd0);
        chk("clean_ferr", 64'(ctl1.firstErrAddr), 64'd0);

        // Seeded pattern: 0x10^A5=B5, 0x11^A5=B4.
        run("seed", 32'h10, 32'h11, 8'hA5, 8, 1'b0);
        chk("seed_nwr", 64'(wq.size()), 64'd2);
        chk("seed_w0", 64'(wq[0]), 64'hB5);
        chk("seed_w1", 64'(wq[1]), 64'hB4);
        chk("seed_pass", 64'(ctl1.pass), 64'd1);

        // Injected fault at address 2.
        fault2 = 1'b1;
        run("fault", 32'd0, 32'd5, 8'h00, 20, 1'b0);
        fault2 = 1'b0;
        chk("fault_err", 64'(ctl1.errCount), 64'd1);
        chk("fault_ferr", 64'(ctl1.firstErrAddr), 64'd2);
        chk("fault_pass", 64'(ctl1.pass), 64'd0);
        repeat (3) @(negedge clk);
        chk("fault_hold_err", 64'(ctl1.errCount), 64'd1);
        chk("fault_hold_pass", 64'(ctl1.pass), 64'd0);

        // Wrap through the top of the address space.
        run("wrap", 32'hFFFF_FFFF, 32'd1, 8'h00, 11, 1'b0);
        chk("wrap_nwr", 64'(wq.size()), 64'd3);
        chk("wrap_a0", 64'(aq[0]), 64'hFFFF_FFFF);
        chk("wrap_a1", 64'(aq[1]), 64'h0);
        chk("wrap_a2", 64'(aq[2]), 64'h1);
        chk("wrap_d0", 64'(wq[0]), 64'hFF);
        chk("wrap_d2", 64'(wq[2]), 64'h01);
        chk("wrap_pass", 64'(ctl1.pass), 64'd1);
        chk("wrap_ferr_cleared", 64'(ctl1.firstErrAddr), 64'd0);

        // Saturation: every read on the second RAM is corrupted, 6 mismatches into 2 bits.
        run("sat", 32'd0, 32'd5, 8'h00, 20, 1'b0);
        chk("sat_err", 64'(ctl2.errCount), 64'd3);
        chk("sat_pass", 64'(ctl2.pass), 64'd0);
        chk("sat_ref_pass", 64'(ctl1.pass), 64'd1);

        // Start while busy must not restart or retarget the test.
        run("busy_start", 32'd0, 32'd1, 8'h3C, 8, 1'b1);
        chk("busy_start_nwr", 64'(wq.size()), 64'd2);
        chk("busy_start_a1", 64'(aq[1]), 64'd1);
        chk("busy_start_d1", 64'(wq[1]), 64'h3D);
        chk("busy_start_pass", 64'(ctl1.pass), 64'd1);

        // Reset asserted during cycle 3 of a write burst.
        @(negedge clk);
        startAddr = 32'd0; endAddr = 32'd9; seed = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_before", 64'(we1), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", 64'(we1), 64'd0);
        chk("mid_rst_re", 64'(re1), 64'd0);
        chk("mid_rst_busy", 64'(ctl1.busy), 64'd0);
        chk("mid_rst_done", 64'(ctl1.done), 64'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (ctl1.done || we1 || re1) done_seen++;
            @(negedge clk);
        end
        chk("mid_rst_quiet", 64'(done_seen), 64'd0);

        run("post_rst", 32'd7, 32'd7, 8'h07, 5, 1'b0);
        chk("post_rst_d0", 64'(wq[0]), 64'h00);
        chk("post_rst_pass", 64'(ctl1.pass), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_bist.md
# ram_bist

Synthesizable built-in self-test initiator for `simpleRAM`. It drives the RAM's `we`, `re`, `addr` and bidirectional `data` pins from the initiator side of the interface. It fills an address window with a seeded pattern, reads it back, compares each word and reports a pass/fail summary. It sits beside `simpleRAM` in the memory subsystem and shares the RAM's clock.

## Interface

Parameters:
- `wordSize`, 8, RAM data width in bits.
- `addressSize`, 32, RAM address width in bits.
- `errWidth`, 16, width of the saturating error counter.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begins a test when sampled high in IDLE.
- `startAddr`  input  addressSize  first address, latched at start.
- `endAddr`  input  addressSize  last address (inclusive), latched at start.
- `seed`  input  wordSize  pattern seed, latched at start.
- `we`  output  1  RAM write enable.
- `re`  output  1  RAM read enable.
- `addr`  output  addressSize  RAM address.
- `data`  inout  wordSize  RAM data bus; driven only while `we`=1, else high-Z.
- `busy`  output  1  high from the cycle after start until done.
- `done`  output  1  one-cycle pulse at test completion.
- `pass`  output  1  1 if the last test had zero mismatches; valid from `done`.
- `errCount`  output  errWidth  mismatch count, saturating at all-ones.
- `firstErrAddr`  output  addressSize  address of first mismatch; 0 if none.

## Operation

- Pattern: `pat(a) = a[wordSize-1:0] ^ seed`. Address bits above wordSize are ignored.
- FSM states: IDLE, WRITE, TURN, RD_ADDR, RD_DATA, DONE.
- IDLE
  - `start`=1 latches the inputs, sets `cur`=startAddr, clears `errCount`, `firstErrAddr` and the first-error flag, and goes to WRITE.
  - `start`=0 holds all results.
- WRITE
  - Outputs: `we`=1, `addr`=cur, `data`=pat(cur).
  - If cur==endAddr: cur←startAddr, go to TURN.
  - Else: cur←cur+1, modulo 2^addressSize.
- TURN: one idle cycle, we=re=0, bus high-Z, for bus turnaround.
- RD_ADDR: `re`=1, `addr`=cur, then go to RD_DATA.
- RD_DATA
  - Outputs: `re`=1, `addr`=cur. Sample `data` at the closing edge.
  - On mismatch: errCount += 1, saturating. The first mismatch records firstErrAddr=cur.
  - If cur==endAddr, go to DONE. Else cur←cur+1 and go to RD_ADDR.
- DONE: `done`=1 for one cycle, `pass`=(errCount==0), then go to IDLE.
- Wrap-around: if endAddr < startAddr, the window wraps through the maximum address to 0. startAddr==endAddr tests exactly one word.
- `start` while busy is ignored.
- Reset values: we=0, re=0, addr=0, data high-Z, busy=0, done=0, pass=0, errCount=0, firstErrAddr=0, state IDLE.
- Reset mid-test aborts at the next edge: we/re drop and the bus is released in that cycle. No done pulse is produced.

## Timing

- RAM contract:
  - A write commits on the rising edge where we=1.
  - For a read, the RAM drives data in the cycle after re is first seen high, while re stays high.
- Cycle numbering: start sampled at edge 0.
  - WRITE occupies cycles 1..N, for N window words.
  - TURN occupies cycle N+1.
  - Reads occupy cycles N+2..3N+1, two cycles per word.
  - `done` is high in cycle 3N+2.
- `busy` is high in cycles 1..3N+2.
- All outputs are registered. `data` output-enable equals registered `we`.
- we and re are never both high. The bus is never driven in TURN, RD_ADDR or RD_DATA.

## Structure

- Shared package `ram_pkg`:
  - FSM state enum.
  - The `pat()` function, so the bench's reference model uses the identical pattern.
- Natural sub-module `ram_bist_addr_gen`:
  - Holds the window registers and the wrapping address counter.
  - Outputs `cur` and `last` (cur==endAddr).
  - Inputs `load` and `inc`.
- The FSM, comparator and error bookkeeping stay in `ram_bist`.

## Test plan

- Clean run: start=1, startAddr=0, endAddr=3, seed=8'h00, real simpleRAM.
  - Writes 00,01,02,03 in cycles 1–4.
  - done in cycle 14, pass=1, errCount=0.
- Seeded pattern: seed=8'hA5, window 0x10–0x11.
  - Bus carries B5 then B4.
  - done in cycle 8, pass=1.
- Injected fault: RAM model forces addr 2 to read 8'hFF, window 0–5, seed 0.
  - errCount=1, firstErrAddr=2, pass=0.
- Wrap: startAddr=32'hFFFF_FFFF, endAddr=1.
  - Addresses FFFFFFFF, 0, 1 are written then read.
  - done in cycle 11.
- Saturation with errWidth=2: every read corrupted, window of 6 words → errCount=3, pass=0.
- Robustness: start during busy is ignored. rst asserted in cycle 3 → we=re=0, bus high-Z, busy=0, no done pulse.
